imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Hardware boot path that fills the pipelined CPU's instruction memory from a byte stream, replacing bench-side preloading.
- Holds the CPU in reset while loading, assembles little-endian 32-bit words and writes them to consecutive word addresses from 0.
- Stops after writing the halt sentinel word, then releases the CPU.
- Sits between an external byte source (UART/JTAG bridge) and the imem write port / CPU reset.

Parameters:
- ADDR_WIDTH, 8, imem word-address width.
- MAX_WORDS, 256, imem capacity in words; must be <= 2**ADDR_WIDTH.
- HALT_WORD, 32'hFFFFFFFF, end-of-program sentinel; it is written to imem, then loading stops.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored in LOAD.
- s_valid  in  1  byte source valid.
- s_ready  out  1  loader accepts a byte; a byte transfers when s_valid && s_ready at posedge.
- s_data  in  8  byte payload.
- imem_we  out  1  one-cycle imem write strobe.
- imem_addr  out  ADDR_WIDTH  imem word address.
- imem_wdata  out  32  imem write data.
- cpu_reset  out  1  active-high CPU reset hold.
- done  out  1  load complete, CPU running.
- error  out  1  overflow: MAX_WORDS written without the sentinel.
- word_count  out  ADDR_WIDTH+1  words written in the current or last load.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, word_count=0, byte index=0.
- All outputs are registered.
- States: IDLE, LOAD, DONE, ERR.
- IDLE: s_ready=0, cpu_reset=1. start -> LOAD.
- Entering LOAD from any state:
  - clears byte index, write address, word_count, done and error.
  - sets cpu_reset=1 on the same edge.
- LOAD, byte assembly:
  - s_ready=1. Each accepted byte goes to assembly lane byte_idx (byte 0 = bits 7:0).
  - byte_idx increments modulo 4.
  - Stalls on s_valid=0 are unbounded; no timeout.
- LOAD, word write:
  - The edge that accepts byte 3 registers imem_wdata = assembled word and imem_addr = current address.
  - imem_we=1 for exactly the following cycle; the address then increments and word_count increments.
  - Throughput: one byte per cycle. Byte 0 of the next word may be accepted during the imem_we cycle, because the assembly buffer is separate from imem_wdata.
- LOAD -> DONE: the completed word equals HALT_WORD.
  - The sentinel is still written.
  - s_ready drops on the same edge, so no byte is accepted after the sentinel.
  - cpu_reset=0 and done=1 one edge later. This is the edge that ends the imem_we cycle, so the write lands before the CPU leaves reset.
- LOAD -> ERR: a non-sentinel word is written at address MAX_WORDS-1.
  - That write still occurs.
  - s_ready=0 on the same edge; error=1 the next edge; cpu_reset stays 1.
- Address never wraps: overflow always goes to ERR.
- DONE: s_ready=0, done=1, cpu_reset=0. start -> LOAD (reload; CPU re-held in reset).
- ERR: s_ready=0, error=1, cpu_reset=1. start -> LOAD.
- Partial word:
  - Bytes left in assembly when leaving LOAD are discarded.
  - Leaving LOAD with a partial word is only possible via reset.
- Reset mid-load: immediate return to reset values. imem contents already written are left as is.
- start in the same cycle as a byte in LOAD: the byte is accepted and start is ignored.
- start in the same cycle as the transition into DONE/ERR: start is ignored.

Decomposition:
- Shared package (cpu_pkg): loader state encoding, HALT_WORD default, imem depth constant (shared with instruction_memory).
- Natural sub-module: byte_to_word_packer.
  - Byte-lane register plus index counter.
  - Emits a word_valid pulse and a 32-bit word.
- FSM, address counter and strobe generation stay in imem_loader.

Test Plan:
- Basic load:
  - Stimulus: start, then 28 bytes back-to-back for the 7-word program 00100213, 00100413, 00100413, 00400463, 00400313, 00400293, FFFFFFFF, sent little-endian (13 02 10 00 ...).
  - Response: 7 imem_we pulses at addr 0..6 with those words; word_count=7; done=1 and cpu_reset=0 one cycle after the last write; s_ready=0 afterwards.
- Back-pressure/gaps:
  - Stimulus: same stream with s_valid deasserted 3 cycles between every byte.
  - Response: identical writes and data; each write occurs exactly one cycle after its byte 3 is accepted.
- Overflow:
  - Stimulus: MAX_WORDS=4; send 5 words with no sentinel.
  - Response: writes at addr 0..3 only; error=1; cpu_reset=1; s_ready=0; 5th word not accepted.
- Reset mid-load:
  - Stimulus: reset low after 2 words + 2 bytes.
  - Response: all outputs at reset values asynchronously. A new start followed by a full stream writes from addr 0.
- Ignored and accepted start:
  - Stimulus: start pulse during LOAD.
  - Response: no restart; word_count keeps counting.
  - Stimulus: start after DONE.
  - Response: cpu_reset=1 and done=0 on the next edge; reload writes from addr 0 again.
- Sentinel handling:
  - Stimulus: FFFFFFFF as the first word.
  - Response: a single write of FFFFFFFF at addr 0; word_count=1; done=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: state encoding,
// imem depth and the default end-of-program sentinel.
package imem_loader_pkg;

    localparam int          IMEM_DEPTH        = 256;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the boot loader.
// The master side is the loader; the slave side is the byte source / imem.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
);
    logic                  s_valid;
    logic                  s_ready;
    byte_t                 s_data;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        input  s_valid, s_data,
        output s_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_byte_to_word_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid marks the
// cycle in which byte 3 is offered, with the full word presented alongside.
module byte_to_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  byte_t       byte_data,
    output logic        word_valid,
    output logic [31:0] word
);
    byte_t      lane0, lane1, lane2;
    logic [1:0] byte_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx <= 2'd0;
            lane0    <= '0;
            lane1    <= '0;
            lane2    <= '0;
        end else if (clear) begin
            byte_idx <= 2'd0;
        end else if (byte_en) begin
            case (byte_idx)
                2'd0:    lane0 <= byte_data;
                2'd1:    lane1 <= byte_data;
                2'd2:    lane2 <= byte_data;
                default: ;
            endcase
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // Byte 3 bypasses the lane registers so the word is ready on its own edge.
    assign word       = {byte_data, lane2, lane1, lane0};
    assign word_valid = byte_en && (byte_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: holds the CPU in reset, streams bytes into imem words from
// address 0 until the halt sentinel is written, then releases the CPU.
//
// state | meaning
// IDLE  | after reset, CPU held, waiting for start
// LOAD  | accepting bytes, writing words
// DONE  | sentinel written, CPU running (first cycle finishes the write)
// ERR   | imem filled without sentinel, CPU held (first cycle finishes the write)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter int          MAX_WORDS  = IMEM_DEPTH,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    imem_loader_if.master       bus,
    output logic                cpu_reset,
    output logic                done,
    output logic                error,
    output logic [ADDR_WIDTH:0] word_count
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            state;
    logic                  s_ready_q;
    logic                  imem_we_q;
    logic [ADDR_WIDTH-1:0] imem_addr_q;
    logic [31:0]           imem_wdata_q;
    logic [ADDR_WIDTH-1:0] wr_addr;

    logic                  accept;
    logic                  restart;
    logic                  word_valid;
    logic [31:0]           word;

    assign accept  = bus.s_valid && s_ready_q;
    // A write still in flight (first DONE/ERR cycle) blocks a restart.
    assign restart = start && (state != ST_LOAD) && !imem_we_q;

    byte_to_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .byte_en    (accept),
        .byte_data  (bus.s_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            s_ready_q    <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            wr_addr      <= '0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            word_count   <= '0;
        end else begin
            imem_we_q <= 1'b0;
            if (imem_we_q) begin
                word_count <= word_count + CNT_ONE;
            end

            if (restart) begin
                state      <= ST_LOAD;
                s_ready_q  <= 1'b1;
                cpu_reset  <= 1'b1;
                done       <= 1'b0;
                error      <= 1'b0;
                wr_addr    <= '0;
                word_count <= '0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (word_valid) begin
                            imem_we_q    <= 1'b1;
                            imem_wdata_q <= word;
                            imem_addr_q  <= wr_addr;
                            wr_addr      <= wr_addr + ADDR_ONE;
                            if (word == HALT_WORD) begin
                                state     <= ST_DONE;
                                s_ready_q <= 1'b0;
                            end else if (wr_addr == LAST_ADDR) begin
                                state     <= ST_ERR;
                                s_ready_q <= 1'b0;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (imem_we_q) begin
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end
                    end
                    ST_ERR: begin
                        if (imem_we_q) begin
                            error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a default instance for program loads and
// a MAX_WORDS=4 instance for the overflow path.
module tb_imem_loader;
    import imem_loader_pkg::*;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_m = 1'b0;
    logic       start_o = 1'b0;
    logic       cpu_reset_m, done_m, error_m;
    logic       cpu_reset_o, done_o, error_o;
    logic [8:0] wc_m, wc_o;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q_m[$];
    exp_t q_o[$];
    exp_t e_mon;

    logic [31:0] prog [7] = '{32'h00100213, 32'h00100413, 32'h00100413, 32'h00400463,
                              32'h00400313, 32'h00400293, 32'hFFFFFFFF};

    imem_loader_if #(.ADDR_WIDTH(8)) bus_m ();
    imem_loader_if #(.ADDR_WIDTH(8)) bus_o ();

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start_m),
        .bus        (bus_m),
        .cpu_reset  (cpu_reset_m),
        .done       (done_m),
        .error      (error_m),
        .word_count (wc_m)
    );

    imem_loader #(.MAX_WORDS(4)) dut_ovf (
        .clk        (clk),
        .reset      (reset),
        .start      (start_o),
        .bus        (bus_o),
        .cpu_reset  (cpu_reset_o),
        .done       (done_o),
        .error      (error_o),
        .word_count (wc_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every imem_we cycle must match the oldest expected write,
    // including the edge on which it was launched.
    always @(negedge clk) begin
        if (bus_m.imem_we === 1'b1) begin
            total++;
            if (q_m.size() == 0) begin
                bad++;
                $display("FAIL main_unexpected_write addr=%0d data=%h", bus_m.imem_addr, bus_m.imem_wdata);
            end else begin
                e_mon = q_m.pop_front();
                if (bus_m.imem_addr !== e_mon.addr || bus_m.imem_wdata !== e_mon.data || cyc != e_mon.cyc) begin
                    bad++;
                    $display("FAIL main_write got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                             bus_m.imem_addr, bus_m.imem_wdata, cyc, e_mon.addr, e_mon.data, e_mon.cyc);
                end
            end
        end
        if (bus_o.imem_we === 1'b1) begin
            total++;
            if (q_o.size() == 0) begin
                bad++;
                $display("FAIL ovf_unexpected_write addr=%0d data=%h", bus_o.imem_addr, bus_o.imem_wdata);
            end else begin
                e_mon = q_o.pop_front();
                if (bus_o.imem_addr !== e_mon.addr || bus_o.imem_wdata !== e_mon.data || cyc != e_mon.cyc) begin
                    bad++;
                    $display("FAIL ovf_write got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                             bus_o.imem_addr, bus_o.imem_wdata, cyc, e_mon.addr, e_mon.data, e_mon.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input bit ovf);
        @(negedge clk);
        if (ovf) start_o = 1'b1; else start_m = 1'b1;
        @(posedge clk); #1;
        start_o = 1'b0;
        start_m = 1'b0;
    endtask

    // Returns right after the edge that accepted the byte (or after a timeout).
    task automatic send_byte(input bit ovf, input logic [7:0] b, input bit with_start, output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        @(negedge clk);
        if (ovf) begin
            bus_o.s_valid = 1'b1; bus_o.s_data = b;
        end else begin
            bus_m.s_valid = 1'b1; bus_m.s_data = b;
            if (with_start) start_m = 1'b1;
        end
        while ((ovf ? bus_o.s_ready : bus_m.s_ready) !== 1'b1) begin
            if (n == 40) begin
                total++; bad++;
                $display("FAIL byte_timeout got s_ready=0 want s_ready=1 (byte %h)", b);
                ok = 1'b0;
                bus_o.s_valid = 1'b0; bus_m.s_valid = 1'b0; start_m = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        bus_o.s_valid = 1'b0;
        bus_m.s_valid = 1'b0;
        start_m       = 1'b0;
    endtask

    task automatic send_word(input bit ovf, input logic [31:0] w, input logic [7:0] a,
                             input int gap, input int start_at);
        bit   ok;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            repeat (gap) @(negedge clk);
            send_byte(ovf, w[8*i +: 8], (i == start_at), ok);
            if (ok && i == 3) begin
                e.addr = a; e.data = w; e.cyc = cyc;
                if (ovf) q_o.push_back(e); else q_m.push_back(e);
            end
        end
    endtask

    // Called right after the sentinel's byte 3 was accepted.
    task automatic check_finish(input logic [8:0] want_wc);
        total++;
        if (bus_m.s_ready !== 1'b0 || done_m !== 1'b0 || cpu_reset_m !== 1'b1 || bus_m.imem_we !== 1'b1) begin
            bad++;
            $display("FAIL sentinel_edge got s_ready=%b done=%b cpu_reset=%b we=%b want 0 0 1 1",
                     bus_m.s_ready, done_m, cpu_reset_m, bus_m.imem_we);
        end
        @(posedge clk); #1;
        total++;
        if (done_m !== 1'b1 || cpu_reset_m !== 1'b0 || wc_m !== want_wc || bus_m.s_ready !== 1'b0) begin
            bad++;
            $display("FAIL done_edge got done=%b cpu_reset=%b wc=%0d s_ready=%b want 1 0 %0d 0",
                     done_m, cpu_reset_m, wc_m, bus_m.s_ready, want_wc);
        end
        total++;
        if (q_m.size() != 0) begin
            bad++;
            $display("FAIL missing_writes got pending=%0d want 0", q_m.size());
        end
    endtask

    task automatic test_reset();
        bus_m.s_valid = 1'b0; bus_m.s_data = '0;
        bus_o.s_valid = 1'b0; bus_o.s_data = '0;
        #1 reset = 1'b0;
        #2;
        total++;
        if (bus_m.s_ready !== 1'b0 || bus_m.imem_we !== 1'b0 || bus_m.imem_addr !== 8'd0 || bus_m.imem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_bus got s_ready=%b we=%b addr=%0d wdata=%h want 0 0 0 0",
                     bus_m.s_ready, bus_m.imem_we, bus_m.imem_addr, bus_m.imem_wdata);
        end
        total++;
        if (cpu_reset_m !== 1'b1 || done_m !== 1'b0 || error_m !== 1'b0 || wc_m !== 9'd0) begin
            bad++;
            $display("FAIL reset_status got cpu_reset=%b done=%b error=%b wc=%0d want 1 0 0 0",
                     cpu_reset_m, done_m, error_m, wc_m);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus_m.s_ready !== 1'b0 || cpu_reset_m !== 1'b1) begin
            bad++;
            $display("FAIL idle_hold got s_ready=%b cpu_reset=%b want 0 1", bus_m.s_ready, cpu_reset_m);
        end
    endtask

    task automatic load_program(input int gap);
        pulse_start(1'b0);
        total++;
        if (bus_m.s_ready !== 1'b1 || cpu_reset_m !== 1'b1 || done_m !== 1'b0 || wc_m !== 9'd0) begin
            bad++;
            $display("FAIL load_entry got s_ready=%b cpu_reset=%b done=%b wc=%0d want 1 1 0 0",
                     bus_m.s_ready, cpu_reset_m, done_m, wc_m);
        end
        for (int w = 0; w < 7; w++) send_word(1'b0, prog[w], 8'(w), gap, -1);
        check_finish(9'd7);
    endtask

    task automatic test_basic_load();
        load_program(0);
    endtask

    task automatic test_gaps();
        load_program(3);
    endtask

    task automatic test_start_in_load();
        pulse_start(1'b0);
        send_word(1'b0, prog[0], 8'd0, 0, -1);
        send_word(1'b0, prog[1], 8'd1, 0, 1);
        send_word(1'b0, prog[2], 8'd2, 0, -1);
        send_word(1'b0, prog[3], 8'd3, 0, -1);
        pulse_start(1'b0);
        total++;
        if (wc_m !== 9'd4 || bus_m.s_ready !== 1'b1 || cpu_reset_m !== 1'b1) begin
            bad++;
            $display("FAIL start_ignored got wc=%0d s_ready=%b cpu_reset=%b want 4 1 1",
                     wc_m, bus_m.s_ready, cpu_reset_m);
        end
        for (int w = 4; w < 7; w++) send_word(1'b0, prog[w], 8'(w), 0, -1);
        check_finish(9'd7);
    endtask

    task automatic test_restart_sentinel();
        pulse_start(1'b0);
        total++;
        if (cpu_reset_m !== 1'b1 || done_m !== 1'b0 || wc_m !== 9'd0 || bus_m.s_ready !== 1'b1) begin
            bad++;
            $display("FAIL restart got cpu_reset=%b done=%b wc=%0d s_ready=%b want 1 0 0 1",
                     cpu_reset_m, done_m, wc_m, bus_m.s_ready);
        end
        send_word(1'b0, 32'hFFFFFFFF, 8'd0, 0, -1);
        check_finish(9'd1);
    endtask

    task automatic test_reset_mid();
        bit ok;
        pulse_start(1'b0);
        send_word(1'b0, prog[0], 8'd0, 0, -1);
        send_word(1'b0, prog[1], 8'd1, 0, -1);
        send_byte(1'b0, 8'hAA, 1'b0, ok);
        send_byte(1'b0, 8'hBB, 1'b0, ok);
        #3 reset = 1'b0;
        #1;
        total++;
        if (bus_m.s_ready !== 1'b0 || bus_m.imem_we !== 1'b0 || bus_m.imem_addr !== 8'd0 || bus_m.imem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL midreset_bus got s_ready=%b we=%b addr=%0d wdata=%h want 0 0 0 0",
                     bus_m.s_ready, bus_m.imem_we, bus_m.imem_addr, bus_m.imem_wdata);
        end
        total++;
        if (cpu_reset_m !== 1'b1 || done_m !== 1'b0 || error_m !== 1'b0 || wc_m !== 9'd0) begin
            bad++;
            $display("FAIL midreset_status got cpu_reset=%b done=%b error=%b wc=%0d want 1 0 0 0",
                     cpu_reset_m, done_m, error_m, wc_m);
        end
        @(negedge clk);
        reset = 1'b1;
        load_program(0);
    endtask

    task automatic test_overflow();
        pulse_start(1'b1);
        for (int w = 0; w < 4; w++) send_word(1'b1, prog[w], 8'(w), 0, -1);
        total++;
        if (bus_o.s_ready !== 1'b0 || error_o !== 1'b0) begin
            bad++;
            $display("FAIL ovf_edge got s_ready=%b error=%b want 0 0", bus_o.s_ready, error_o);
        end
        @(posedge clk); #1;
        total++;
        if (error_o !== 1'b1 || cpu_reset_o !== 1'b1 || done_o !== 1'b0 || wc_o !== 9'd4) begin
            bad++;
            $display("FAIL ovf_status got error=%b cpu_reset=%b done=%b wc=%0d want 1 1 0 4",
                     error_o, cpu_reset_o, done_o, wc_o);
        end
        @(negedge clk);
        bus_o.s_valid = 1'b1;
        bus_o.s_data  = 8'h13;
        repeat (8) @(negedge clk);
        total++;
        if (bus_o.s_ready !== 1'b0 || error_o !== 1'b1 || wc_o !== 9'd4) begin
            bad++;
            $display("FAIL ovf_fifth_word got s_ready=%b error=%b wc=%0d want 0 1 4",
                     bus_o.s_ready, error_o, wc_o);
        end
        bus_o.s_valid = 1'b0;
        total++;
        if (q_o.size() != 0) begin
            bad++;
            $display("FAIL ovf_missing_writes got pending=%0d want 0", q_o.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_gaps();
        test_start_in_load();
        test_restart_sentinel();
        test_reset_mid();
        test_overflow();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
